// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module      : multicycle_control_if
// Description : Handshake/strobe bundle between the LEGv8 multicycle sequencer
//               and its datapath and memories.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [10:0]      opcode;
  logic             zero_E;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             AluSrc;
  logic [3:0]       AluControl;
  logic             dmem_read;
  logic             dmem_write;
  logic             reg_write;
  logic             mem_to_reg;
  logic             pc_write;
  logic             pc_src;
  logic [CNT_W-1:0] retired;
  logic             error;

  // Sequencer side
  modport master (
    input  run, opcode, zero_E, imem_ready, dmem_ready,
    output imem_req, ir_write, AluSrc, AluControl, dmem_read, dmem_write,
           reg_write, mem_to_reg, pc_write, pc_src, retired, error
  );

  // Datapath / memory side
  modport slave (
    output run, opcode, zero_E, imem_ready, dmem_ready,
    input  imem_req, ir_write, AluSrc, AluControl, dmem_read, dmem_write,
           reg_write, mem_to_reg, pc_write, pc_src, retired, error
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for LEGv8 with
//               memory-wait timeout, retired counter and sticky error state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  wire logic           clk,
  input  wire logic           reset,
  multicycle_control_if.master bus
);
  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] c_TO_LAST = WCW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    CL_ADD, CL_SUB, CL_AND, CL_ORR, CL_LDUR, CL_STUR, CL_CBZ, CL_B
  } class_t;

  state_t           state_q, state_d;
  class_t           class_q, class_d;
  logic             req_held_q, req_held_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       w_imem_req, w_ir_write, w_alu_src, w_dmem_read, w_dmem_write;
  logic       w_reg_write, w_mem_to_reg, w_pc_write, w_pc_src, w_timeout_hit;
  logic [3:0] w_alu_ctl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      class_q    <= CL_ADD;
      req_held_q <= 1'b0;
      wcnt_q     <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      req_held_q <= req_held_d;
      wcnt_q     <= wcnt_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    req_held_d   = 1'b0;
    wcnt_d       = wcnt_q;
    w_imem_req   = 1'b0;
    w_ir_write   = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_ctl    = 4'b0000;
    w_dmem_read  = 1'b0;
    w_dmem_write = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_timeout_hit = (MEM_TIMEOUT != 0) && (wcnt_q == c_TO_LAST);

    // Execute controls stay fixed from EXEC through WB of one instruction
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (class_q)
        CL_ADD:  w_alu_ctl = 4'b0010;
        CL_SUB:  w_alu_ctl = 4'b0110;
        CL_AND:  w_alu_ctl = 4'b0000;
        CL_ORR:  w_alu_ctl = 4'b0001;
        CL_LDUR, CL_STUR: begin
          w_alu_src = 1'b1;
          w_alu_ctl = 4'b0010;
        end
        CL_CBZ:  w_alu_ctl = 4'b0111;
        default: w_alu_ctl = 4'b0000;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        w_imem_req = bus.run | req_held_q;
        if (w_imem_req) begin
          if (bus.imem_ready) begin
            w_ir_write = 1'b1;
            state_d    = S_DECODE;
            wcnt_d     = '0;
          end else if (w_timeout_hit) begin
            state_d = S_ERROR;
          end else begin
            req_held_d = 1'b1;
            wcnt_d     = wcnt_q + WCW'(1);
          end
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        casez (bus.opcode)
          11'b11111000010: class_d = CL_LDUR;
          11'b11111000000: class_d = CL_STUR;
          11'b10110100???: class_d = CL_CBZ;
          11'b000101?????: class_d = CL_B;
          11'b10001011000: class_d = CL_ADD;
          11'b11001011000: class_d = CL_SUB;
          11'b10001010000: class_d = CL_AND;
          11'b10101010000: class_d = CL_ORR;
          default:         state_d = S_ERROR;
        endcase
      end
      S_EXEC: begin
        wcnt_d = '0;
        case (class_q)
          CL_LDUR, CL_STUR: state_d = S_MEM;
          CL_CBZ: begin
            w_pc_write = 1'b1;
            w_pc_src   = bus.zero_E;
            state_d    = S_FETCH;
          end
          CL_B: begin
            w_pc_write = 1'b1;
            w_pc_src   = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        w_dmem_read  = (class_q == CL_LDUR);
        w_dmem_write = (class_q == CL_STUR);
        if (bus.dmem_ready) begin
          wcnt_d = '0;
          if (class_q == CL_STUR) begin
            w_pc_write = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (w_timeout_hit) begin
          state_d = S_ERROR;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (class_q == CL_LDUR);
        w_pc_write   = 1'b1;
        state_d      = S_FETCH;
        wcnt_d       = '0;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_FETCH;
    endcase

    // Nothing leaks out while reset is held, even mid-instruction
    if (reset) begin
      w_imem_req   = 1'b0;
      w_ir_write   = 1'b0;
      w_alu_src    = 1'b0;
      w_alu_ctl    = 4'b0000;
      w_dmem_read  = 1'b0;
      w_dmem_write = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = 1'b0;
    end

    retired_d = retired_q + {{(CNT_W-1){1'b0}}, w_pc_write};
  end

  assign bus.imem_req   = w_imem_req;
  assign bus.ir_write   = w_ir_write;
  assign bus.AluSrc     = w_alu_src;
  assign bus.AluControl = w_alu_ctl;
  assign bus.dmem_read  = w_dmem_read;
  assign bus.dmem_write = w_dmem_write;
  assign bus.reg_write  = w_reg_write;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.pc_write   = w_pc_write;
  assign bus.pc_src     = w_pc_src;
  assign bus.retired    = retired_q;
  assign bus.error      = (state_q == S_ERROR);
endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control; instruction-level
//               reference model with randomized latencies and opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;
  localparam int TO = 16;
  localparam logic [13:0] M_ALL   = 14'b11111111111111;
  localparam logic [13:0] M_NOALU = 14'b11000001111111;
  localparam logic [13:0] V_IDLE  = 14'b00000000000000;
  localparam logic [13:0] V_ERR   = 14'b00000000000001;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) bus ();

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] exp_ret = 32'd0;
  logic        exp_err = 1'b0;

  function automatic logic [13:0] pk(input logic req, input logic irw, input logic asrc,
                                     input logic [3:0] ac, input logic dr, input logic dw,
                                     input logic rw, input logic m2r, input logic pw,
                                     input logic ps, input logic err);
    return {req, irw, asrc, ac, dr, dw, rw, m2r, pw, ps, err};
  endfunction

  function automatic logic [13:0] obs();
    return pk(bus.imem_req, bus.ir_write, bus.AluSrc, bus.AluControl, bus.dmem_read,
              bus.dmem_write, bus.reg_write, bus.mem_to_reg, bus.pc_write, bus.pc_src,
              bus.error);
  endfunction

  // Instruction class from the opcode table: 0 illegal, 1 LDUR, 2 STUR, 3 CBZ, 4 B, 5..8 R-type
  function automatic int cls(input logic [10:0] op);
    casez (op)
      11'b11111000010: return 1;
      11'b11111000000: return 2;
      11'b10110100???: return 3;
      11'b000101?????: return 4;
      11'b10001011000: return 5;
      11'b11001011000: return 6;
      11'b10001010000: return 7;
      11'b10101010000: return 8;
      default:         return 0;
    endcase
  endfunction

  function automatic logic [4:0] alu(input int c);
    case (c)
      1, 2:    return 5'b1_0010;
      3:       return 5'b0_0111;
      5:       return 5'b0_0010;
      6:       return 5'b0_0110;
      8:       return 5'b0_0001;
      default: return 5'b0_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [13:0] exp, input logic [13:0] mask);
    n_chk++;
    assert (((obs() & mask) === (exp & mask)) && (bus.retired === exp_ret)) n_pass++;
    else $error("FAIL %s: strobes=%b retired=%0d, required strobes=%b retired=%0d",
                tag, obs() & mask, bus.retired, exp & mask, exp_ret);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.run = 1'b1;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    #1;
    chk("in_reset", {13'd0, exp_err}, M_ALL);
    exp_err = 1'b0;
    exp_ret = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    bus.run = 1'b0;
    bus.imem_ready = 1'b0;
    #1;
    chk("post_reset", V_IDLE, M_ALL);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.run = exp_err ? 1'b1 : 1'b0;
      bus.imem_ready = 1'($urandom);
      bus.dmem_ready = 1'($urandom);
      #1;
      chk(exp_err ? "error_hold" : "idle_no_req", exp_err ? V_ERR : V_IDLE, M_ALL);
    end
  endtask

  // Walks one instruction through the pipeline phases, checking every cycle
  task automatic do_instr(input logic [10:0] op, input int ilat, input int dlat,
                          input logic z, input bit drop);
    int         c;
    logic [4:0] a;
    logic [13:0] m;
    logic       retire;
    c = cls(op);
    a = alu(c);
    m = (c == 4) ? M_NOALU : M_ALL;
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (k == 0) bus.run = 1'b1;
      else if (drop) bus.run = 1'b0;
      bus.imem_ready = (k == ilat);
      bus.dmem_ready = 1'($urandom);
      bus.zero_E = 1'($urandom);
      bus.opcode = 11'($urandom);
      #1;
      chk("fetch", pk(1'b1, k == ilat, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
      if (k == ilat) break;
      if (k == TO - 1) begin
        @(negedge clk);
        bus.imem_ready = 1'b0;
        #1;
        exp_err = 1'b1;
        chk("fetch_timeout", V_ERR, M_ALL);
        return;
      end
    end
    @(negedge clk);
    bus.imem_ready = 1'($urandom);
    bus.opcode = op;
    #1;
    chk("decode", V_IDLE, M_ALL);
    if (c == 0) begin
      @(negedge clk);
      #1;
      exp_err = 1'b1;
      chk("illegal_error", V_ERR, M_ALL);
      return;
    end
    @(negedge clk);
    bus.zero_E = z;
    bus.dmem_ready = 1'($urandom);
    #1;
    retire = (c == 3) || (c == 4);
    chk("exec", pk(1'b0, 1'b0, a[4], a[3:0], 1'b0, 1'b0, 1'b0, 1'b0, retire,
                   (c == 3) ? z : (c == 4), 1'b0), m);
    if (retire) begin
      exp_ret++;
      return;
    end
    if (c == 1 || c == 2) begin
      for (int k = 0; ; k++) begin
        @(negedge clk);
        bus.dmem_ready = (k == dlat);
        bus.zero_E = 1'($urandom);
        #1;
        chk("mem", pk(1'b0, 1'b0, a[4], a[3:0], c == 1, c == 2, 1'b0, 1'b0,
                      (c == 2) && (k == dlat), 1'b0, 1'b0), M_ALL);
        if (k == dlat) begin
          if (c == 2) begin
            exp_ret++;
            return;
          end
          break;
        end
        if (k == TO - 1) begin
          @(negedge clk);
          bus.dmem_ready = 1'b0;
          #1;
          exp_err = 1'b1;
          chk("mem_timeout", V_ERR, M_ALL);
          return;
        end
      end
    end
    @(negedge clk);
    bus.dmem_ready = 1'($urandom);
    bus.zero_E = 1'($urandom);
    #1;
    chk("wb", pk(1'b0, 1'b0, a[4], a[3:0], 1'b0, 1'b0, 1'b1, c == 1, 1'b1, 1'b0, 1'b0), M_ALL);
    exp_ret++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] op;
    int          ilat, dlat;
    bit          drop;
    bus.run = 1'b0;
    bus.opcode = '0;
    bus.zero_E = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    do_instr(OP_ADD, 0, 0, 1'b0, 1'b0);
    do_instr(OP_LDUR, 0, 3, 1'b0, 1'b0);
    do_instr(11'b10110100101, 1, 0, 1'b1, 1'b0);
    do_instr(11'b10110100010, 0, 0, 1'b0, 1'b0);
    do_instr(11'b00010110011, 0, 0, 1'b0, 1'b0);
    do_instr(OP_STUR, 0, TO - 1, 1'b0, 1'b0);
    do_instr(OP_STUR, 0, 1000, 1'b0, 1'b0);
    idle(3);
    do_reset();
    do_instr(11'b11111111111, 0, 0, 1'b0, 1'b0);
    idle(2);
    do_reset();
    do_instr(OP_ADD, 2, 0, 1'b0, 1'b1);
    idle(3);
    do_instr(OP_SUB, 1000, 0, 1'b0, 1'b0);
    idle(2);
    do_reset();

    // Reset arriving in WB must suppress reg_write/pc_write
    do_instr(OP_ORR, 0, 0, 1'b0, 1'b0);
    @(negedge clk); bus.run = 1'b1; bus.imem_ready = 1'b1;
    @(negedge clk); bus.opcode = OP_AND;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       op = OP_LDUR;
        1:       op = OP_STUR;
        2:       op = {8'b10110100, 3'($urandom)};
        3:       op = {6'b000101, 5'($urandom)};
        4:       op = OP_ADD;
        5:       op = OP_SUB;
        6:       op = OP_AND;
        7:       op = OP_ORR;
        8:       op = OP_LDUR;
        default: op = 11'($urandom);
      endcase
      ilat = ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        0:       dlat = TO - 1;
        1:       dlat = 30;
        default: dlat = $urandom_range(0, 5);
      endcase
      drop = (ilat >= 1) && ($urandom_range(0, 3) == 0);
      do_instr(op, ilat, dlat, 1'($urandom), drop);
      if (exp_err) begin
        idle(2);
        do_reset();
      end else if (drop) begin
        idle(2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
